// File: rtl/mac_frame_packer_if.sv
// ============================================================================
//  Module   : mac_frame_packer_if
//  Purpose  : 32-bit valid/ready word stream between the packer and its sink.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface mac_frame_packer_if;
  logic [31:0] data_out;
  logic        data_valid;
  logic        data_ready;

  modport master (
    output data_out,
    output data_valid,
    input  data_ready
  );

  modport slave (
    input  data_out,
    input  data_valid,
    output data_ready
  );
endinterface

`default_nettype wire

// File: rtl/mac_frame_packer.sv
// ============================================================================
//  Module   : mac_frame_packer
//  Purpose  : Packs a padded Ethernet header into a 32-bit valid/ready stream.
//  Options  : MAC_PACKER_VLAN_EN adds vlan_tag and inserts it before ethertype.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mac_frame_packer #(
  parameter logic [7:0] PAD_BYTE  = 8'h00,
  parameter logic [7:0] FILL_BYTE = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        start,
  input  logic [47:0] dst_mac,
  input  logic [47:0] src_mac,
  input  logic [15:0] ethertype,
  input  logic [1:0]  byte_offset,
`ifdef MAC_PACKER_VLAN_EN
  input  logic [31:0] vlan_tag,
`endif
  output logic        busy,
  output logic        done,
  mac_frame_packer_if.master m_if
);

`ifdef MAC_PACKER_VLAN_EN
  localparam int HDR_BYTES = 18;
`else
  localparam int HDR_BYTES = 14;
`endif
  localparam int HDR_BITS   = 8 * HDR_BYTES;
  localparam int STAGE_BITS = 192;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [STAGE_BITS-1:0]   stage_q, stage_d;
  logic [STAGE_BITS-1:0]   stage_cap;
  logic [HDR_BITS-1:0]     hdr;
  logic [2:0]              cnt_q, cnt_d;
  logic [2:0]              last_q, last_d;
  logic [2:0]              last_cap;
  logic [31:0]             data_out_q, data_out_d;
  logic                    data_valid_q, data_valid_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    xfer;

`ifdef MAC_PACKER_VLAN_EN
  assign hdr = {dst_mac, src_mac, vlan_tag, ethertype};
`else
  assign hdr = {dst_mac, src_mac, ethertype};
`endif

  // Staging vector: byte 0 of the stream sits in the top byte lane.
  always_comb begin
    stage_cap = '0;
    for (int i = 0; i < 24; i++) begin
      if (i < int'(byte_offset)) begin
        stage_cap[STAGE_BITS-1-8*i -: 8] = PAD_BYTE;
      end else if (i < int'(byte_offset) + HDR_BYTES) begin
        stage_cap[STAGE_BITS-1-8*i -: 8] = hdr[HDR_BITS-1-8*(i-int'(byte_offset)) -: 8];
      end else begin
        stage_cap[STAGE_BITS-1-8*i -: 8] = FILL_BYTE;
      end
    end
  end

  assign last_cap = 3'((HDR_BYTES + int'(byte_offset) + 3) / 4 - 1);

  function automatic logic [31:0] word_at(input logic [STAGE_BITS-1:0] s,
                                          input logic [2:0] k);
    logic [STAGE_BITS-1:0] sh;
    sh = s << (32 * int'(k));
    return sh[STAGE_BITS-1 -: 32];
  endfunction

  assign xfer = data_valid_q && m_if.data_ready;

  always_comb begin
    state_d      = state_q;
    stage_d      = stage_q;
    cnt_d        = cnt_q;
    last_d       = last_q;
    data_out_d   = data_out_q;
    data_valid_d = data_valid_q;
    busy_d       = busy_q;
    done_d       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d      = ST_SEND;
          stage_d      = stage_cap;
          last_d       = last_cap;
          cnt_d        = 3'd0;
          data_out_d   = stage_cap[STAGE_BITS-1 -: 32];
          data_valid_d = 1'b1;
          busy_d       = 1'b1;
        end
      end
      ST_SEND: begin
        if (xfer) begin
          if (cnt_q == last_q) begin
            state_d      = ST_DONE;
            data_valid_d = 1'b0;
            busy_d       = 1'b0;
            done_d       = 1'b1;
          end else begin
            cnt_d      = cnt_q + 3'd1;
            data_out_d = word_at(stage_q, cnt_q + 3'd1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort wins over any capture or transfer in the same cycle.
    if (clear) begin
      state_d      = ST_IDLE;
      cnt_d        = 3'd0;
      data_out_d   = 32'd0;
      data_valid_d = 1'b0;
      busy_d       = 1'b0;
      done_d       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      stage_q      <= '0;
      cnt_q        <= 3'd0;
      last_q       <= 3'd0;
      data_out_q   <= 32'd0;
      data_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      stage_q      <= stage_d;
      cnt_q        <= cnt_d;
      last_q       <= last_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign m_if.data_out   = data_out_q;
  assign m_if.data_valid = data_valid_q;
  assign busy            = busy_q;
  assign done            = done_q;

endmodule

`default_nettype wire

// File: tb/tb_mac_frame_packer.sv
// ============================================================================
//  Module   : tb_mac_frame_packer
//  Purpose  : Directed self-checking bench for mac_frame_packer.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mac_frame_packer;
  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        start;
  logic [47:0] dst_mac;
  logic [47:0] src_mac;
  logic [15:0] ethertype;
  logic [1:0]  byte_offset;
`ifdef MAC_PACKER_VLAN_EN
  logic [31:0] vlan_tag;
`endif
  logic        busy;
  logic        done;

  int tests = 0;
  int fails = 0;

  mac_frame_packer_if bus ();

  mac_frame_packer dut (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear),
    .start       (start),
    .dst_mac     (dst_mac),
    .src_mac     (src_mac),
    .ethertype   (ethertype),
    .byte_offset (byte_offset),
`ifdef MAC_PACKER_VLAN_EN
    .vlan_tag    (vlan_tag),
`endif
    .busy        (busy),
    .done        (done),
    .m_if        (bus.master)
  );

  always #5 clk = ~clk;

  // Pulse start for one capture edge; returns #1 after that edge.
  task automatic issue_start(input logic [1:0] off);
    byte_offset = off;
    start       = 1'b1;
    @(posedge clk);
    #1;
    start       = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    tests++;
    if (bus.data_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", bus.data_valid); end
    tests++;
    if (bus.data_out !== 32'h0) begin fails++; $display("FAIL reset_data: got %h expected 00000000", bus.data_out); end
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tests++;
    if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", done); end
  endtask

  task automatic test_offset0();
    logic [31:0] exp [4];
    exp = '{32'h00112233, 32'h4455AABB, 32'hCCDDEEFF, 32'h08000000};
    issue_start(2'd0);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      tests++;
      if (bus.data_valid !== 1'b1 || bus.data_out !== exp[k] || busy !== 1'b1)
        begin fails++; $display("FAIL off0_word%0d: got v=%b d=%h busy=%b expected v=1 d=%h busy=1", k, bus.data_valid, bus.data_out, busy, exp[k]); end
    end
    @(posedge clk); #1;
    tests++;
    if (done !== 1'b1 || bus.data_valid !== 1'b0 || busy !== 1'b0)
      begin fails++; $display("FAIL off0_done: got done=%b v=%b busy=%b expected 1 0 0", done, bus.data_valid, busy); end
    @(posedge clk); #1;
    tests++;
    if (done !== 1'b0) begin fails++; $display("FAIL off0_done_pulse: got done=%b expected 0", done); end
  endtask

  task automatic test_offset3();
    logic [31:0] exp [5];
    exp = '{32'h00000000, 32'h11223344, 32'h55AABBCC, 32'hDDEEFF08, 32'h00000000};
    issue_start(2'd3);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      tests++;
      if (bus.data_valid !== 1'b1 || bus.data_out !== exp[k])
        begin fails++; $display("FAIL off3_word%0d: got v=%b d=%h expected v=1 d=%h", k, bus.data_valid, bus.data_out, exp[k]); end
    end
    @(posedge clk); #1;
    tests++;
    if (done !== 1'b1 || bus.data_valid !== 1'b0)
      begin fails++; $display("FAIL off3_done: got done=%b v=%b expected 1 0", done, bus.data_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    logic [31:0] exp [4];
    exp = '{32'h00112233, 32'h4455AABB, 32'hCCDDEEFF, 32'h08000000};
    issue_start(2'd0);
    tests++;
    if (bus.data_out !== exp[0]) begin fails++; $display("FAIL bp_word0: got %h expected %h", bus.data_out, exp[0]); end
    @(posedge clk); #1;
    bus.data_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      tests++;
      if (bus.data_valid !== 1'b1 || bus.data_out !== exp[1])
        begin fails++; $display("FAIL bp_hold%0d: got v=%b d=%h expected v=1 d=%h", c, bus.data_valid, bus.data_out, exp[1]); end
    end
    bus.data_ready = 1'b1;
    for (int k = 2; k < 4; k++) begin
      @(posedge clk); #1;
      tests++;
      if (bus.data_valid !== 1'b1 || bus.data_out !== exp[k])
        begin fails++; $display("FAIL bp_word%0d: got v=%b d=%h expected v=1 d=%h", k, bus.data_valid, bus.data_out, exp[k]); end
    end
    @(posedge clk); #1;
    tests++;
    if (done !== 1'b1) begin fails++; $display("FAIL bp_done: got %b expected 1", done); end
    @(posedge clk); #1;
  endtask

  task automatic test_clear();
    logic [31:0] exp [4];
    exp = '{32'h00001122, 32'h334455AA, 32'hBBCCDDEE, 32'hFF080000};
    issue_start(2'd0);
    @(posedge clk); #1;   // word 0 accepted
    @(posedge clk); #1;   // word 1 accepted
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    tests++;
    if (bus.data_valid !== 1'b0 || bus.data_out !== 32'h0 || busy !== 1'b0 || done !== 1'b0)
      begin fails++; $display("FAIL clear_state: got v=%b d=%h busy=%b done=%b expected 0 00000000 0 0", bus.data_valid, bus.data_out, busy, done); end
    @(posedge clk); #1;
    tests++;
    if (done !== 1'b0 || bus.data_valid !== 1'b0)
      begin fails++; $display("FAIL clear_no_done: got done=%b v=%b expected 0 0", done, bus.data_valid); end
    issue_start(2'd1);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      tests++;
      if (bus.data_valid !== 1'b1 || bus.data_out !== exp[k])
        begin fails++; $display("FAIL clear_refr_word%0d: got v=%b d=%h expected v=1 d=%h", k, bus.data_valid, bus.data_out, exp[k]); end
    end
    @(posedge clk); #1;
    tests++;
    if (done !== 1'b1) begin fails++; $display("FAIL clear_refr_done: got %b expected 1", done); end
    @(posedge clk); #1;
  endtask

  task automatic test_start_ignored();
    logic [31:0] exp [4];
    int done_cnt = 0;
    exp = '{32'h00000011, 32'h22334455, 32'hAABBCCDD, 32'hEEFF0800};
    byte_offset = 2'd2;
    start       = 1'b1;
    @(posedge clk); #1;
    dst_mac     = 48'hFFFF_FFFF_FFFF;   // captured value must be used
    byte_offset = 2'd0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      tests++;
      if (bus.data_valid !== 1'b1 || bus.data_out !== exp[k])
        begin fails++; $display("FAIL ign_word%0d: got v=%b d=%h expected v=1 d=%h", k, bus.data_valid, bus.data_out, exp[k]); end
    end
    @(posedge clk); #1;
    if (done === 1'b1) done_cnt++;
    @(posedge clk); #1;   // start still high while leaving DONE
    start = 1'b0;
    tests++;
    if (bus.data_valid !== 1'b0 || busy !== 1'b0)
      begin fails++; $display("FAIL ign_after_done: got v=%b busy=%b expected 0 0", bus.data_valid, busy); end
    for (int c = 0; c < 3; c++) begin
      if (done === 1'b1) done_cnt++;
      @(posedge clk); #1;
    end
    tests++;
    if (done_cnt != 1 || bus.data_valid !== 1'b0)
      begin fails++; $display("FAIL ign_one_frame: got done pulses=%0d v=%b expected 1 0", done_cnt, bus.data_valid); end
    dst_mac = 48'h0011_2233_4455;
  endtask

`ifdef MAC_PACKER_VLAN_EN
  task automatic test_vlan();
    logic [31:0] exp [5];
    exp = '{32'h00000011, 32'h22334455, 32'hAABBCCDD, 32'hEEFF8100, 32'h00640800};
    vlan_tag = 32'h81000064;
    issue_start(2'd2);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      tests++;
      if (bus.data_valid !== 1'b1 || bus.data_out !== exp[k])
        begin fails++; $display("FAIL vlan_word%0d: got v=%b d=%h expected v=1 d=%h", k, bus.data_valid, bus.data_out, exp[k]); end
    end
    @(posedge clk); #1;
    tests++;
    if (done !== 1'b1) begin fails++; $display("FAIL vlan_done: got %b expected 1", done); end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    rst            = 1'b1;
    clear          = 1'b0;
    start          = 1'b0;
    dst_mac        = 48'h0011_2233_4455;
    src_mac        = 48'hAABB_CCDD_EEFF;
    ethertype      = 16'h0800;
    byte_offset    = 2'd0;
    bus.data_ready = 1'b1;
`ifdef MAC_PACKER_VLAN_EN
    vlan_tag       = 32'h0;
`endif
    test_reset();
    test_offset0();
    test_offset3();
    test_backpressure();
    test_clear();
    test_start_ignored();
`ifdef MAC_PACKER_VLAN_EN
    test_vlan();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
